// File: rtl/cell_update_queue.sv
// Changed-cell FIFO between frame_tracker and the draw stage.
// Drops that happen while the queue is full are flagged so the controller can request a full redraw.
package cell_update_queue_pkg;
   typedef enum logic [2:0] {
      OBJ_BLANK  = 3'd0,
      OBJ_BODY   = 3'd1,
      OBJ_HEAD   = 3'd2,
      OBJ_APPLE  = 3'd3,
      OBJ_BORDER = 3'd4
   } obj_code_t;
endpackage

module cell_update_queue
   import cell_update_queue_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int X_W   = 4,
   parameter int Y_W   = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enable,
   input  logic                       diff,
   input  logic [X_W-1:0]             x,
   input  logic [Y_W-1:0]             y,
   input  obj_code_t                  obj_code,
   input  logic                       sync,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [X_W-1:0]             out_x,
   output logic [Y_W-1:0]             out_y,
   output obj_code_t                  out_obj,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow,
   output logic                       redraw_req
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = $clog2(DEPTH+1);
   localparam int OBJ_W   = 3;
   localparam int ENTRY_W = X_W + Y_W + OBJ_W;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [ENTRY_W-1:0] mem_q [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             redraw_q, redraw_d;

   logic             full_w, empty_w;
   logic             cell_changed, push, pop, drop;
   logic [ENTRY_W-1:0] wr_entry, head_entry;

   assign full_w       = (count_q == DEPTH_C);
   assign empty_w      = (count_q == '0);
   assign cell_changed = enable && diff;
   assign pop          = !empty_w && out_ready;
   // A full queue still accepts a push when the head leaves in the same cycle.
   assign push         = cell_changed && (!full_w || pop);
   assign drop         = cell_changed && full_w && !pop;
   assign wr_entry     = {x, y, obj_code};

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      redraw_d   = 1'b0;

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // At a frame boundary the old frame's status is reported and cleared,
      // but a drop in the boundary cycle belongs to the new frame.
      if (sync) begin
         redraw_d   = overflow_q;
         overflow_d = drop;
      end else if (drop) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         redraw_q   <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         redraw_q   <= redraw_d;
      end
   end

   // Storage is not reset; stale contents are masked by out_valid below.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_q[wr_ptr_q] <= wr_entry;
      end
   end

   assign head_entry = mem_q[rd_ptr_q];

   always_comb begin
      out_x   = '0;
      out_y   = '0;
      out_obj = OBJ_BLANK;
      if (!empty_w) begin
         out_x   = head_entry[ENTRY_W-1 -: X_W];
         out_y   = head_entry[OBJ_W +: Y_W];
         out_obj = obj_code_t'(head_entry[OBJ_W-1:0]);
      end
   end

   assign out_valid  = !empty_w;
   assign count      = count_q;
   assign full       = full_w;
   assign empty      = empty_w;
   assign overflow   = overflow_q;
   assign redraw_req = redraw_q;

endmodule

// File: tb/tb_cell_update_queue.sv
// Directed bench for cell_update_queue: ordering, full/drop handling, frame-boundary flags and reset.
module tb_cell_update_queue;
   import cell_update_queue_pkg::*;

   localparam int DEPTH = 16;
   localparam int X_W   = 4;
   localparam int Y_W   = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             enable, diff, sync, out_ready;
   logic [X_W-1:0]   x;
   logic [Y_W-1:0]   y;
   obj_code_t        obj_code;
   logic             out_valid;
   logic [X_W-1:0]   out_x;
   logic [Y_W-1:0]   out_y;
   obj_code_t        out_obj;
   logic [4:0]       count;
   logic             full, empty, overflow, redraw_req;

   int checks_cnt = 0;
   int errors_cnt = 0;

   cell_update_queue #(.DEPTH(DEPTH), .X_W(X_W), .Y_W(Y_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .diff       (diff),
      .x          (x),
      .y          (y),
      .obj_code   (obj_code),
      .sync       (sync),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_x      (out_x),
      .out_y      (out_y),
      .out_obj    (out_obj),
      .count      (count),
      .full       (full),
      .empty      (empty),
      .overflow   (overflow),
      .redraw_req (redraw_req)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks_cnt++;
      if (obs !== exp) begin
         errors_cnt++;
         $display("FAIL %s got %0d expected %0d", tag, obs, exp);
      end else begin
         $display("ok   %s = %0d", tag, obs);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cell(input int cx, input int cy, input int co);
      x        = X_W'(cx);
      y        = Y_W'(cy);
      obj_code = obj_code_t'(co);
   endtask

   task automatic check_head(input string tag, input int ex, input int ey, input int eo);
      check({tag, ".valid"}, int'(out_valid), 1);
      check({tag, ".x"}, int'(out_x), ex);
      check({tag, ".y"}, int'(out_y), ey);
      check({tag, ".obj"}, int'(out_obj), eo);
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; diff = 1'b0; sync = 1'b0; out_ready = 1'b0;
      set_cell(0, 0, 0);
      step(); step();
      rst = 1'b0;
      check("rst.count", int'(count), 0);
      check("rst.empty", int'(empty), 1);
      check("rst.full", int'(full), 0);
      check("rst.valid", int'(out_valid), 0);
      check("rst.overflow", int'(overflow), 0);
      check("rst.redraw", int'(redraw_req), 0);
      check("rst.out_x", int'(out_x), 0);

      // 1: three pushes with the draw stage stalled
      enable = 1'b1; diff = 1'b1; set_cell(1, 2, OBJ_HEAD);
      step();
      check_head("t1.first", 1, 2, OBJ_HEAD);
      set_cell(1, 3, OBJ_BODY);
      step();
      set_cell(5, 5, OBJ_APPLE);
      step();
      enable = 1'b0; diff = 1'b0;
      check("t1.count", int'(count), 3);
      step(); step();
      check_head("t1.hold", 1, 2, OBJ_HEAD);

      // 2: drain in push order
      out_ready = 1'b1;
      check_head("t2.e0", 1, 2, OBJ_HEAD);
      step();
      check_head("t2.e1", 1, 3, OBJ_BODY);
      step();
      check_head("t2.e2", 5, 5, OBJ_APPLE);
      step();
      check("t2.empty", int'(empty), 1);
      check("t2.valid", int'(out_valid), 0);
      check("t2.count", int'(count), 0);
      out_ready = 1'b0;

      // 3: 17 pushes into a 16-deep queue, then frame boundary
      enable = 1'b1; diff = 1'b1;
      for (int i = 0; i < 17; i++) begin
         set_cell(i % 16, 15 - (i % 16), (i == 16) ? OBJ_BORDER : (i % 5));
         step();
      end
      enable = 1'b0; diff = 1'b0;
      check("t3.full", int'(full), 1);
      check("t3.count", int'(count), 16);
      check("t3.overflow", int'(overflow), 1);
      sync = 1'b1;
      step();
      sync = 1'b0;
      check("t3.redraw", int'(redraw_req), 1);
      check("t3.ovf_clr", int'(overflow), 0);
      step();
      check("t3.redraw_end", int'(redraw_req), 0);

      // 4: push and pop together while full
      enable = 1'b1; diff = 1'b1; out_ready = 1'b1; set_cell(9, 9, OBJ_BORDER);
      check_head("t4.pre", 0, 15, 0);
      step();
      enable = 1'b0; diff = 1'b0;
      check("t4.count", int'(count), 16);
      check("t4.overflow", int'(overflow), 0);
      for (int i = 1; i < 16; i++) begin
         check_head($sformatf("t4.e%0d", i), i, 15 - i, i % 5);
         step();
      end
      check_head("t4.new", 9, 9, OBJ_BORDER);
      step();
      check("t4.empty", int'(empty), 1);
      out_ready = 1'b0;

      // 5: non-diff strobes and diff without strobe are ignored
      enable = 1'b1; diff = 1'b0;
      for (int i = 0; i < 10; i++) step();
      check("t5.en_nodiff", int'(count), 0);
      enable = 1'b0; diff = 1'b1;
      for (int i = 0; i < 3; i++) step();
      check("t5.diff_noen", int'(count), 0);
      diff = 1'b0;

      // drop on a sync edge keeps overflow set for the new frame
      enable = 1'b1; diff = 1'b1;
      for (int i = 0; i < 17; i++) begin
         set_cell(i % 16, i % 16, OBJ_BODY);
         step();
      end
      check("t5b.overflow", int'(overflow), 1);
      sync = 1'b1;
      step();
      sync = 1'b0; enable = 1'b0; diff = 1'b0;
      check("t5b.redraw", int'(redraw_req), 1);
      check("t5b.ovf_keep", int'(overflow), 1);

      // 6: reset with entries queued and overflow set
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) step();
      out_ready = 1'b0;
      check("t6.count_pre", int'(count), 7);
      check("t6.ovf_pre", int'(overflow), 1);
      rst = 1'b1; enable = 1'b1; diff = 1'b1; out_ready = 1'b1;
      step();
      rst = 1'b0; out_ready = 1'b0;
      check("t6.count", int'(count), 0);
      check("t6.valid", int'(out_valid), 0);
      check("t6.overflow", int'(overflow), 0);
      check("t6.redraw", int'(redraw_req), 0);
      set_cell(3, 4, OBJ_APPLE);
      step();
      enable = 1'b0; diff = 1'b0;
      check_head("t6.post", 3, 4, OBJ_APPLE);
      check("t6.count_post", int'(count), 1);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
